// File: rtl/pll_ctrl_pkg.sv
// PLL bring-up controller: shared defaults, state encoding, width helper.
// Imported by pll_lock_ctrl.
package pll_ctrl_pkg;

  localparam int RST_CYCLES_DEF   = 20;
  localparam int LOCK_STABLE_DEF  = 1024;
  localparam int LOCK_TIMEOUT_DEF = 50000;
  localparam int MAX_RETRY_DEF    = 3;

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  // Counter width for a limit, never narrower than one bit
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Synchronous active-high reset clears every stage.
module bit_sync #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[DEPTH-2:0], i_d};
  end

  assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset sequencer: pulses PLL reset, waits for stable lock,
// releases system reset, retries on timeout and faults when exhausted.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES   = RST_CYCLES_DEF,
  parameter int LOCK_STABLE  = LOCK_STABLE_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int MAX_RETRY    = MAX_RETRY_DEF
) (
  input  logic                          refclk,
  input  logic                          rst,
  input  logic                          pll_locked,
  input  logic                          restart,
  output logic                          pll_rst,
  output logic                          sys_rst,
  output logic                          ready,
  output logic                          fault,
  output logic [cw(MAX_RETRY+1)-1:0]    retry_cnt,
  output logic [7:0]                    lost_lock_cnt
);

  localparam int RW = cw(RST_CYCLES);
  localparam int TW = cw(LOCK_TIMEOUT);
  localparam int SW = cw(LOCK_STABLE);
  localparam int CW = cw(MAX_RETRY + 1);

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] RETRY_MAX = CW'(MAX_RETRY);

  logic          w_locked_s;
  state_t        r_state;
  state_t        w_nxt;
  logic [RW-1:0] r_rst_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [SW-1:0] r_stb_cnt;
  logic [CW-1:0] r_retry_cnt;
  logic [7:0]    r_lost_cnt;
  logic          r_pll_rst;
  logic          r_sys_rst;
  logic          r_ready;
  logic          r_fault;

  bit_sync #(.DEPTH(2)) u_sync (
    .i_clk (refclk),
    .i_rst (rst),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  // Lock is checked before timeout so a coincident lock wins
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_RESET_PLL: if (r_rst_cnt == RST_LAST) w_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (w_locked_s)
          w_nxt = S_STABLE;
        else if (r_to_cnt == TO_LAST)
          w_nxt = (r_retry_cnt == RETRY_MAX) ? S_FAULT : S_RESET_PLL;
      end
      S_STABLE: begin
        if (!w_locked_s)
          w_nxt = S_WAIT_LOCK;
        else if (r_stb_cnt == STB_LAST)
          w_nxt = S_RUN;
      end
      S_RUN:   if (!w_locked_s) w_nxt = S_RESET_PLL;
      S_FAULT: if (restart) w_nxt = S_RESET_PLL;
      default: w_nxt = S_RESET_PLL;
    endcase
  end

  // Outputs decode the next state so they change on the transition edge
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= S_RESET_PLL;
      r_rst_cnt   <= '0;
      r_to_cnt    <= '0;
      r_stb_cnt   <= '0;
      r_retry_cnt <= '0;
      r_lost_cnt  <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_nxt;

      r_rst_cnt <= (r_state == S_RESET_PLL && w_nxt == S_RESET_PLL)
                 ? r_rst_cnt + 1'b1 : '0;
      r_to_cnt  <= (r_state == S_WAIT_LOCK && w_nxt == S_WAIT_LOCK)
                 ? r_to_cnt + 1'b1 : '0;
      r_stb_cnt <= (r_state == S_STABLE && w_nxt == S_STABLE)
                 ? r_stb_cnt + 1'b1 : '0;

      if (r_state == S_WAIT_LOCK && w_nxt == S_RESET_PLL)
        r_retry_cnt <= r_retry_cnt + 1'b1;
      else if (r_state == S_STABLE && w_nxt == S_RUN)
        r_retry_cnt <= '0;
      else if (r_state == S_FAULT && w_nxt == S_RESET_PLL)
        r_retry_cnt <= '0;

      if (r_state == S_RUN && w_nxt == S_RESET_PLL && r_lost_cnt != 8'hFF)
        r_lost_cnt <= r_lost_cnt + 8'd1;

      r_pll_rst <= (w_nxt == S_RESET_PLL) || (w_nxt == S_FAULT);
      r_sys_rst <= (w_nxt != S_RUN);
      r_ready   <= (w_nxt == S_RUN);
      r_fault   <= (w_nxt == S_FAULT);
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_rst       = r_sys_rst;
  assign ready         = r_ready;
  assign fault         = r_fault;
  assign retry_cnt     = r_retry_cnt;
  assign lost_lock_cnt = r_lost_cnt;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: directed timing scenarios plus random lock
// traffic compared against a phase/duration reference model.
module tb_pll_lock_ctrl;

  localparam int RC = 4;
  localparam int LS = 8;
  localparam int LT = 32;
  localparam int MR = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, sys_rst, ready, fault;
  logic [1:0] retry_cnt;
  logic [7:0] lost_lock_cnt;

  int n_chk = 0;
  int n_pass = 0;

  always #10 refclk = ~refclk;

  pll_lock_ctrl #(
    .RST_CYCLES(RC), .LOCK_STABLE(LS),
    .LOCK_TIMEOUT(LT), .MAX_RETRY(MR)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
    .restart(restart), .pll_rst(pll_rst), .sys_rst(sys_rst),
    .ready(ready), .fault(fault), .retry_cnt(retry_cnt),
    .lost_lock_cnt(lost_lock_cnt)
  );

  // Reference model: phase, cycles spent in phase, and the
  // two-cycle-old view of pll_locked that the controller reacts to
  typedef enum int {M_RST, M_WAIT, M_STB, M_RUN, M_FLT} mph_t;
  mph_t     m_ph = M_RST;
  int       m_age = 0;
  int       m_retry = 0;
  int       m_lost = 0;
  bit [1:0] m_hist = 2'b00;

  task automatic enter(input mph_t p);
    m_ph = p;
    m_age = 0;
  endtask

  task automatic model_step();
    bit ls;
    ls = m_hist[1];
    m_hist = {m_hist[0], pll_locked};
    if (rst) begin
      enter(M_RST);
      m_retry = 0;
      m_lost = 0;
      m_hist = 2'b00;
      return;
    end
    case (m_ph)
      M_RST: begin
        m_age++;
        if (m_age == RC) enter(M_WAIT);
      end
      M_WAIT: begin
        if (ls) enter(M_STB);
        else begin
          m_age++;
          if (m_age == LT) begin
            if (m_retry == MR) enter(M_FLT);
            else begin m_retry++; enter(M_RST); end
          end
        end
      end
      M_STB: begin
        if (!ls) enter(M_WAIT);
        else begin
          m_age++;
          if (m_age == LS) begin m_retry = 0; enter(M_RUN); end
        end
      end
      M_RUN: begin
        if (!ls) begin
          m_lost = (m_lost < 255) ? m_lost + 1 : 255;
          enter(M_RST);
        end
      end
      M_FLT: begin
        if (restart) begin m_retry = 0; enter(M_RST); end
      end
      default: enter(M_RST);
    endcase
  endtask

  function automatic logic [13:0] exp_bundle();
    return {(m_ph == M_RST) || (m_ph == M_FLT), m_ph != M_RUN,
            m_ph == M_RUN, m_ph == M_FLT, 2'(m_retry), 8'(m_lost)};
  endfunction

  function automatic logic [13:0] obs_bundle();
    return {pll_rst, sys_rst, ready, fault, retry_cnt, lost_lock_cnt};
  endfunction

  task automatic tick();
    @(posedge refclk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    restart = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ready; i++) tick();
    if (ready) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    restart = 1'b1;
    pll_locked = 1'($urandom);
    repeat (3) tick();
    n_chk++; if (pll_rst !== 1'b1) $display("FAIL rst_pll_rst: got %b want 1", pll_rst); else n_pass++;
    n_chk++; if (sys_rst !== 1'b1) $display("FAIL rst_sys_rst: got %b want 1", sys_rst); else n_pass++;
    n_chk++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", ready); else n_pass++;
    n_chk++; if (fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", fault); else n_pass++;
    n_chk++; if (retry_cnt !== 2'd0) $display("FAIL rst_retry: got %0d want 0", retry_cnt); else n_pass++;
    n_chk++; if (lost_lock_cnt !== 8'd0) $display("FAIL rst_lost: got %0d want 0", lost_lock_cnt); else n_pass++;
    restart = 1'b0;
  endtask

  task automatic test_bringup();
    int hi;
    rst = 1'b1;
    pll_locked = 1'b0;
    tick();
    rst = 1'b0;
    hi = pll_rst ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pll_rst) hi++;
      else break;
    end
    n_chk++; if (hi != RC) $display("FAIL bringup_pll_rst_len: got %0d want %0d", hi, RC); else n_pass++;
    repeat (4) tick();
    pll_locked = 1'b1;
    tick();
    repeat (LS + 1) tick();
    n_chk++; if ({sys_rst, ready} !== 2'b10) $display("FAIL bringup_early: got %b want 10", {sys_rst, ready}); else n_pass++;
    tick();
    n_chk++; if ({sys_rst, ready} !== 2'b01) $display("FAIL bringup_release: got %b want 01", {sys_rst, ready}); else n_pass++;
    n_chk++; if (retry_cnt !== 2'd0) $display("FAIL bringup_retry: got %0d want 0", retry_cnt); else n_pass++;
    n_chk++; if (obs_bundle() !== exp_bundle()) $display("FAIL bringup_model: got %h want %h", obs_bundle(), exp_bundle()); else n_pass++;
  endtask

  task automatic test_glitch();
    bit held;
    pll_locked = 1'b0;
    do_reset();
    repeat (6) tick();
    pll_locked = 1'b1;
    tick();
    repeat (7) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    tick();
    n_chk++; if ({sys_rst, ready} !== 2'b10) $display("FAIL glitch_hold: got %b want 10", {sys_rst, ready}); else n_pass++;
    held = 1'b1;
    repeat (LS) begin
      tick();
      if (sys_rst !== 1'b1) held = 1'b0;
    end
    n_chk++; if (!held) $display("FAIL glitch_fresh_count: got early release want held"); else n_pass++;
    tick();
    n_chk++; if ({sys_rst, ready} !== 2'b01) $display("FAIL glitch_release: got %b want 01", {sys_rst, ready}); else n_pass++;
  endtask

  task automatic test_retry();
    int widths[$];
    int retries[$];
    int run, n;
    bit prev, held;
    pll_locked = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prev = pll_rst;
    run = 1;
    retries.push_back(int'(retry_cnt));
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n++;
      if (fault) break;
      if (pll_rst && !prev) begin
        run = 1;
        retries.push_back(int'(retry_cnt));
      end else if (pll_rst) run++;
      else if (prev) widths.push_back(run);
      prev = pll_rst;
    end
    n_chk++; if (n != 3 * (RC + LT)) $display("FAIL retry_fault_time: got %0d want %0d", n, 3 * (RC + LT)); else n_pass++;
    n_chk++; if (widths.size() != 3) $display("FAIL retry_pulses: got %0d want 3", widths.size()); else n_pass++;
    foreach (widths[i]) begin
      n_chk++; if (widths[i] != RC) $display("FAIL retry_width%0d: got %0d want %0d", i, widths[i], RC); else n_pass++;
    end
    foreach (retries[i]) begin
      n_chk++; if (retries[i] != i) $display("FAIL retry_cnt%0d: got %0d want %0d", i, retries[i], i); else n_pass++;
    end
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pll_locked = 1'($urandom);
      tick();
      if ({fault, pll_rst, sys_rst, ready} !== 4'b1110) held = 1'b0;
    end
    n_chk++; if (!held) $display("FAIL fault_sticky: got left FAULT want held"); else n_pass++;
    pll_locked = 1'b0;
    repeat (3) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_chk++; if ({fault, pll_rst, retry_cnt} !== 4'b0100) $display("FAIL restart: got %b want 0100", {fault, pll_rst, retry_cnt}); else n_pass++;
    run = 0;
    while (pll_rst && run < 20) begin
      run++;
      tick();
    end
    n_chk++; if (run != RC) $display("FAIL restart_width: got %0d want %0d", run, RC); else n_pass++;
  endtask

  task automatic test_loss();
    bit ok;
    int d, run, errs, tmo, want;
    logic [7:0] base;
    pll_locked = 1'b1;
    do_reset();
    wait_ready(60, ok);
    n_chk++; if (!ok) $display("FAIL loss_bringup: got no ready want ready"); else n_pass++;
    base = lost_lock_cnt;
    pll_locked = 1'b0;
    tick();
    for (d = 1; d <= 3; d++) begin
      tick();
      if (sys_rst) break;
    end
    n_chk++; if ({sys_rst, ready} !== 2'b10) $display("FAIL loss_latency: got %b want 10 within 3", {sys_rst, ready}); else n_pass++;
    n_chk++; if (lost_lock_cnt !== base + 8'd1) $display("FAIL loss_count: got %0d want %0d", lost_lock_cnt, base + 8'd1); else n_pass++;
    run = 0;
    while (pll_rst && run < 20) begin
      run++;
      tick();
    end
    n_chk++; if (run != RC) $display("FAIL loss_pll_rst_len: got %0d want %0d", run, RC); else n_pass++;
    pll_locked = 1'b1;
    wait_ready(60, ok);
    errs = 0;
    tmo = ok ? 0 : 1;
    for (int i = 0; i < 259; i++) begin
      pll_locked = 1'b0;
      repeat (3) tick();
      pll_locked = 1'b1;
      wait_ready(60, ok);
      if (!ok) tmo++;
      want = (i + 2 < 255) ? i + 2 : 255;
      if (int'(lost_lock_cnt) != want) errs++;
    end
    n_chk++; if (tmo != 0) $display("FAIL loss_relock_timeout: got %0d want 0", tmo); else n_pass++;
    n_chk++; if (errs != 0) $display("FAIL loss_count_track: got %0d bad want 0", errs); else n_pass++;
    n_chk++; if (lost_lock_cnt !== 8'd255) $display("FAIL loss_saturate: got %0d want 255", lost_lock_cnt); else n_pass++;
  endtask

  task automatic test_mid_reset();
    int n;
    bit ok;
    pll_locked = 1'b1;
    do_reset();
    repeat (7) tick();
    rst = 1'b1;
    restart = 1'b1;
    tick();
    n_chk++; if (obs_bundle() !== 14'b1100_00_00000000) $display("FAIL midrst_stable: got %b want 11000000000000", obs_bundle()); else n_pass++;
    rst = 1'b0;
    restart = 1'b0;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    n_chk++; if (n != RC + 1 + LS) $display("FAIL midrst_rebring: got %0d want %0d", n, RC + 1 + LS); else n_pass++;
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    wait_ready(60, ok);
    n_chk++; if (!ok || lost_lock_cnt !== 8'd1) $display("FAIL midrst_prep: got ok=%b lost=%0d want ok=1 lost=1", ok, lost_lock_cnt); else n_pass++;
    rst = 1'b1;
    restart = 1'b1;
    tick();
    n_chk++; if (obs_bundle() !== 14'b1100_00_00000000) $display("FAIL midrst_run: got %b want 11000000000000", obs_bundle()); else n_pass++;
    rst = 1'b0;
    restart = 1'b0;
    tick();
    n_chk++; if (obs_bundle() !== exp_bundle()) $display("FAIL midrst_model: got %h want %h", obs_bundle(), exp_bundle()); else n_pass++;
  endtask

  task automatic test_random();
    int seg, shown;
    seg = 0;
    shown = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        pll_locked = 1'($urandom);
        seg = ($urandom % 4 == 0) ? $urandom_range(60, 200) : $urandom_range(1, 20);
      end
      seg--;
      restart = ($urandom % 30 == 0);
      rst = ($urandom % 500 == 0);
      tick();
      n_chk++;
      if (obs_bundle() !== exp_bundle()) begin
        if (shown < 20) $display("FAIL random_c%0d: got %b want %b", i, obs_bundle(), exp_bundle());
        shown++;
      end else n_pass++;
    end
    rst = 1'b0;
    restart = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_glitch();
    test_retry();
    test_loss();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
